blink_period_meter: RTL



---
 rtl/blink_meter_pkg.sv | 13 +
 rtl/sync_edge_detect.sv | 66 ++++++
 rtl/blink_period_meter.sv | 106 ++++++++++
 3 files changed

// File: rtl/blink_meter_pkg.sv
// Shared types and default constants for blink_period_meter and its front end.
package blink_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH          = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200_000_000;
  localparam int MIN_SYNC_STAGES        = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer, optional glitch filter (BLINK_PERIOD_METER_GLITCH_FILTER_EN) and
// history flop; emits single-cycle rise/fall pulses of the synchronized level.
module sync_edge_detect
  import blink_meter_pkg::*;
#(
  parameter int SYNC_STAGES = MIN_SYNC_STAGES,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < MIN_SYNC_STAGES || FILTER_LEN < 1) begin : g_param_check
    $error("sync_edge_detect: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   synced;
  logic                   level;
  logic                   level_d;

  // Stage 0: metastability chain on the asynchronous input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_p0 <= '0;
    else          sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig};
  end

  assign synced = sync_p0[SYNC_STAGES-1];

`ifdef BLINK_PERIOD_METER_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [FCW-1:0] run;

  // Stage 1: level follows synced only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= 1'b0;
      run   <= '0;
    end else if (synced != level) begin
      if (run == FCW'(FILTER_LEN - 1)) begin
        level <= synced;
        run   <= '0;
      end else begin
        run <= run + FCW'(1);
      end
    end else begin
      run <= '0;
    end
  end
`else
  assign level = synced;
`endif

  // Stage 2: history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_d <= 1'b0;
    else          level_d <= level;
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/blink_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clock cycles,
// with sticky loss-of-signal flag. Optional glitch filter: BLINK_PERIOD_METER_GLITCH_FILTER_EN.
module blink_period_meter
  import blink_meter_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int SYNC_STAGES    = MIN_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sig,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout
);

  if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << WIDTH) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("blink_period_meter: TIMEOUT_CYCLES must be in [1, 2**WIDTH)");
  end

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT_CYCLES);

  function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_front (
    .clk    (i_clk),
    .reset_n(i_reset_n),
    .sig    (i_sig),
    .rise   (rise),
    .fall   (fall)
  );

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] hi_lat, hi_nxt;
  logic [WIDTH-1:0] period_nxt, high_nxt;
  logic             valid_nxt, timeout_nxt;

  assign cnt_inc = incr(cnt);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi_lat;
    period_nxt  = o_period;
    high_nxt    = o_high;
    valid_nxt   = 1'b0;
    timeout_nxt = o_timeout;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rise) state_nxt = MEASURE;
      end
      MEASURE: begin
        cnt_nxt = cnt_inc;
        if (fall) hi_nxt = cnt_inc;
        // A rise coinciding with the timeout count is still a valid period
        if (rise) begin
          period_nxt  = cnt_inc;
          high_nxt    = hi_lat;
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b0;
          cnt_nxt     = '0;
        end else if (cnt_inc == TIMEOUT_W) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 3: state, counter and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi_lat    <= hi_nxt;
      o_period  <= period_nxt;
      o_high    <= high_nxt;
      o_valid   <= valid_nxt;
      o_timeout <= timeout_nxt;
    end
  end

endmodule
